// File: rtl/bus_host_bridge.sv
// bus_host_bridge: assembles host bytes into 32-bit command words and
// serializes busmaster response words back to the host, with packet flush.
module bus_host_bridge #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_we_o,
    input  logic        cmd_full_i,
    input  logic        rsp_empty_i,
    input  logic [31:0] rsp_data_i,
    input  logic        rsp_pktend_i,
    output logic        rsp_re_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_flush_o,
    output logic        rx_drop_o
);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FLUSH} state_e;

    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] cmd_q, cmd_d;
    logic        we_q, we_d, drop_q, drop_d;
    logic        rx_fire;

    state_e      state_q;
    logic [23:0] sh_q;
    logic [1:0]  idx_q;
    logic        pend_q, tx_valid_q, tx_flush_q;
    logic [7:0]  tx_data_q;

    assign rx_ready_o = !cmd_full_i && !we_q && !rst_i;
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign cmd_data_o = cmd_q;
    assign cmd_we_o   = we_q;
    assign rx_drop_o  = drop_q;

    // Bytes shift in from the top so byte k ends up in bits [8k+7:8k].
    always_comb begin
        cnt_d  = cnt_q;
        tmo_d  = tmo_q;
        buf_d  = buf_q;
        cmd_d  = cmd_q;
        we_d   = 1'b0;
        drop_d = 1'b0;
        if (rx_fire) begin
            cnt_d = cnt_q + 2'd1;
            tmo_d = '0;
            buf_d = {rx_data_i, buf_q[23:8]};
            cmd_d = (cnt_q == 2'd3) ? {rx_data_i, buf_q} : cmd_q;
            we_d  = (cnt_q == 2'd3);
        end else if (cnt_q == 2'd0) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            cnt_d  = '0;
            tmo_d  = '0;
            drop_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tmo_q  <= '0;
            buf_q  <= '0;
            cmd_q  <= '0;
            we_q   <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            buf_q  <= buf_d;
            cmd_q  <= cmd_d;
            we_q   <= we_d;
            drop_q <= drop_d;
        end
    end

    // Read strobe is issued from IDLE so the word arrives during FETCH.
    assign rsp_re_o   = (state_q == IDLE) && !rsp_empty_i && !rst_i;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_flush_o = tx_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_flush_q <= 1'b0;
        end else begin
            tx_flush_q <= 1'b0;
            case (state_q)
                IDLE: state_q <= rsp_empty_i ? IDLE : FETCH;
                FETCH: begin
                    sh_q       <= rsp_data_i[31:8];
                    tx_data_q  <= rsp_data_i[7:0];
                    pend_q     <= rsp_pktend_i;
                    idx_q      <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: if (tx_ready_i) begin
                    idx_q     <= idx_q + 2'd1;
                    tx_data_q <= sh_q[7:0];
                    sh_q      <= {8'd0, sh_q[23:8]};
                    if (idx_q == 2'd3) begin
                        tx_valid_q <= 1'b0;
                        tx_flush_q <= pend_q;
                        state_q    <= pend_q ? FLUSH : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_host_bridge.sv
// tb_bus_host_bridge: table vectors, directed corner sequences and random
// traffic checked against a queue-based reference of the bridge behaviour.
module tb_bus_host_bridge;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst, rx_valid, cmd_full, rsp_empty, rsp_pktend, tx_ready;
    logic [7:0]  rx_data;
    logic [31:0] rsp_data;
    logic        rx_ready, cmd_we, rsp_re, tx_valid, tx_flush, rx_drop;
    logic [31:0] cmd_data;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    bus_host_bridge #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .cmd_data_o(cmd_data), .cmd_we_o(cmd_we), .cmd_full_i(cmd_full),
        .rsp_empty_i(rsp_empty), .rsp_data_i(rsp_data), .rsp_pktend_i(rsp_pktend),
        .rsp_re_o(rsp_re), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .tx_flush_o(tx_flush), .rx_drop_o(rx_drop)
    );

    int vectors = 0, miscompares = 0;

    logic [7:0]  m_part[$];
    int          m_idle = 0;
    bit          m_we = 0, m_drop = 0;
    logic [31:0] m_word = '0;
    logic [32:0] fifo[$];
    logic [8:0]  exp_tx[$];
    bit          owed = 0, prev_stall = 0;
    logic [7:0]  prev_data = '0;
    logic        obs_rdy;
    int          cyc = 0, n_we = 0, n_drop = 0, n_flush = 0, n_re = 0, n_pushed = 0;
    int          re_log[$];
    logic [7:0]  tx_log[$];

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  d;
        bit          full;
        bit          e_rdy;
        bit          e_we;
        logic [31:0] e_data;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic push_rsp(input logic [31:0] w, input bit pend);
        fifo.push_back({pend, w});
        n_pushed++;
        rsp_empty = 1'b0;
    endtask

    // Called at posedge+1; samples at the negedge, advances one clock, then checks.
    task automatic cycle();
        bit fire, s_re, s_txv, s_rdy;
        logic [7:0]  s_txd;
        logic [8:0]  e;
        logic [32:0] w;
        #4;
        obs_rdy = rx_ready;
        check("rx_ready", rx_ready, !cmd_full && !m_we && !rst);
        check("tx_flush", tx_flush, owed);
        if (tx_flush) check("valid_in_flush", tx_valid, 0);
        if (prev_stall) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, prev_data);
        end
        if (rsp_re) check("re_when_empty", rsp_empty, 0);
        if (rst) check("re_in_reset", rsp_re, 0);
        n_flush += int'(tx_flush);
        fire  = rx_valid && !cmd_full && !m_we && !rst;
        s_re  = rsp_re;
        s_txv = tx_valid;
        s_txd = tx_data;
        s_rdy = tx_ready;
        @(posedge clk);
        #1;
        cyc++;
        rsp_data   = $urandom;
        rsp_pktend = 1'($urandom_range(0, 1));
        if (rst) begin
            m_part.delete();
            m_idle = 0; m_we = 0; m_drop = 0; m_word = '0;
            exp_tx.delete();
            owed = 0; prev_stall = 0;
        end else begin
            m_we = 0; m_drop = 0; owed = 0;
            if (fire) begin
                m_part.push_back(rx_data);
                m_idle = 0;
                if (m_part.size() == 4) begin
                    m_word = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    m_part.delete();
                    m_we = 1;
                end
            end else if (m_part.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_part.delete();
                    m_idle = 0;
                    m_drop = 1;
                end
            end
            if (s_txv && s_rdy) begin
                tx_log.push_back(s_txd);
                if (exp_tx.size() == 0) fail("tx_unexpected_byte");
                else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", s_txd, e[7:0]);
                    owed = e[8];
                end
            end
            prev_stall = s_txv && !s_rdy;
            prev_data  = s_txd;
            if (s_re) begin
                if (fifo.size() == 0) fail("rsp_pop_empty");
                else begin
                    w = fifo.pop_front();
                    for (int k = 0; k < 4; k++) exp_tx.push_back({(k == 3) && w[32], w[8*k +: 8]});
                    rsp_data   = w[31:0];
                    rsp_pktend = w[32];
                end
                n_re++;
                re_log.push_back(cyc);
            end
        end
        rsp_empty = (fifo.size() == 0);
        check("cmd_we", cmd_we, m_we);
        check("rx_drop", rx_drop, m_drop);
        check("cmd_data", cmd_data, m_word);
        n_we   += int'(cmd_we);
        n_drop += int'(rx_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 10 && !ok; i++) begin
            cycle();
            ok = obs_rdy;
        end
        rx_valid = 1'b0;
        if (!ok) fail("send_byte_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c;
        bit seen;
        tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 1, 8'h78, 0, 1, 0, 32'h0};
        tbl[2]  = '{0, 1, 8'h56, 0, 1, 0, 32'h0};
        tbl[3]  = '{0, 1, 8'h34, 0, 1, 0, 32'h0};
        tbl[4]  = '{0, 1, 8'h12, 0, 1, 1, 32'h12345678};
        tbl[5]  = '{0, 1, 8'hAA, 0, 0, 0, 32'h12345678};
        tbl[6]  = '{0, 1, 8'hAA, 1, 0, 0, 32'h12345678};
        tbl[7]  = '{0, 1, 8'hAA, 0, 1, 0, 32'h12345678};
        tbl[8]  = '{0, 1, 8'hBB, 0, 1, 0, 32'h12345678};
        tbl[9]  = '{0, 1, 8'hCC, 1, 0, 0, 32'h12345678};
        tbl[10] = '{0, 1, 8'hCC, 0, 1, 0, 32'h12345678};
        tbl[11] = '{0, 1, 8'hDD, 0, 1, 1, 32'hDDCCBBAA};
        tbl[12] = '{0, 0, 8'h00, 0, 0, 0, 32'hDDCCBBAA};

        rst = 1; rx_valid = 0; rx_data = 0; cmd_full = 0; rsp_empty = 1;
        rsp_data = 0; rsp_pktend = 0; tx_ready = 0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; rx_valid = tbl[i].v; rx_data = tbl[i].d; cmd_full = tbl[i].full;
            cycle();
            check($sformatf("tbl%0d_ready", i), obs_rdy, tbl[i].e_rdy);
            check($sformatf("tbl%0d_we", i), cmd_we, tbl[i].e_we);
            check($sformatf("tbl%0d_data", i), cmd_data, tbl[i].e_data);
        end
        rx_valid = 0;
        check("reset_we_out", cmd_we, 0);

        a = n_drop; b = n_we;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle(TMO + 5);
        check("timeout_drop_count", n_drop - a, 1);
        check("timeout_no_we", n_we - b, 0);
        a = n_drop; b = n_we;
        send_byte(8'h11);
        idle(TMO - 1);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("byte_wins_word", cmd_data, 32'h44332211);
        check("byte_wins_no_drop", n_drop - a, 0);
        check("byte_wins_we", n_we - b, 1);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("deadbeef_we", cmd_we, 1);
        check("deadbeef_data", cmd_data, 32'hDEADBEEF);
        idle(2);

        tx_ready = 1;
        re_log.delete(); tx_log.delete();
        a = n_flush;
        push_rsp(32'hDAD1ABCD, 1);
        push_rsp(32'h01020304, 0);
        push_rsp(32'h05060708, 0);
        idle(30);
        check("tx_reads", re_log.size(), 3);
        if (re_log.size() == 3) begin
            check("tx_period_flush", re_log[1] - re_log[0], 7);
            check("tx_period_plain", re_log[2] - re_log[1], 6);
        end
        check("tx_flush_count", n_flush - a, 1);
        check("tx_log_len", tx_log.size(), 12);
        if (tx_log.size() >= 4)
            check("tx_first_word", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'hDAD1ABCD);

        send_byte(8'hAA); send_byte(8'hBB);
        tx_ready = 0;
        push_rsp(32'h11223344, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = tx_valid;
        end
        if (!seen) fail("wait_send_timeout");
        cycle();
        rst = 1; rx_valid = 1; rx_data = 8'h55;
        cycle();
        check("rst_ready", obs_rdy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_flush", tx_flush, 0);
        check("rst_cmd_we", cmd_we, 0);
        check("rst_rx_drop", rx_drop, 0);
        check("rst_cmd_data", cmd_data, 0);
        rst = 0; rx_valid = 0; tx_ready = 1;
        a = n_we;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("post_rst_data", cmd_data, 32'h04030201);
        check("post_rst_we", n_we - a, 1);
        c = n_flush;
        idle(10);
        check("post_rst_no_flush", n_flush - c, 0);

        for (int i = 0; i < 3000; i++) begin
            rx_valid = (i % 300 < 240) ? 1'($urandom_range(0, 1)) : 1'b0;
            rx_data  = 8'($urandom);
            cmd_full = ($urandom_range(0, 4) == 0);
            tx_ready = 1'($urandom_range(0, 1));
            if (fifo.size() < 3 && $urandom_range(0, 3) == 0)
                push_rsp($urandom, 1'($urandom_range(0, 1)));
            cycle();
        end

        rx_valid = 0; cmd_full = 0; tx_ready = 1;
        idle(60);
        check("drain_fifo_empty", fifo.size(), 0);
        check("drain_tx_empty", exp_tx.size(), 0);
        check("one_read_per_word", n_re, n_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
